// File: rtl/wave_pkg.sv
// wave_pkg: shared types for the note sequencer
package wave_pkg;
  localparam int seq_note_w = 2;
  localparam int seq_dur_w = 16;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} seq_state_e;
  typedef struct packed {
    logic                  rest;
    logic [seq_note_w-1:0] note;
    logic [seq_dur_w-1:0]  dur;
  } seq_step_t;
endpackage

// File: rtl/tick_down_counter.sv
// tick_down_counter: loadable down counter advanced by sample ticks, flags the final tick
module tick_down_counter #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] val_i,
  input  logic               tick_i,
  output logic               last_o
);
  logic [width_p-1:0] cnt;
  assign last_o = cnt == width_p'(1);
  // load wins over a tick; the count parks at zero
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) cnt <= '0;
    else if (load_i) cnt <= val_i;
    else if (tick_i && cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/wave_note_sequencer.sv
// wave_note_sequencer: steps through a programmed note pattern, gating the oscillator bank per sample tick
module wave_note_sequencer
  import wave_pkg::*;
#(
  parameter int voices_p    = 4,
  parameter int steps_p     = 16,
  parameter int dur_width_p = 16,
  parameter int gap_ticks_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       sample_tick_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       loop_i,
  input  logic [$clog2(steps_p)-1:0] len_i,
  input  logic                       cfg_we_i,
  input  logic [$clog2(steps_p)-1:0] cfg_addr_i,
  input  logic                       cfg_rest_i,
  input  logic [$clog2(voices_p)-1:0] cfg_note_i,
  input  logic [dur_width_p-1:0]     cfg_dur_i,
  output logic [voices_p-1:0]        osc_en_o,
  output logic                       gate_o,
  output logic [$clog2(steps_p)-1:0] step_o,
  output logic                       busy_o,
  output logic                       done_o
);
  localparam int nw = $clog2(voices_p);
  localparam int sw = $clog2(steps_p);
  localparam int gw = $clog2(gap_ticks_p + 2);
  seq_state_e state, state_n;
  seq_step_t mem [steps_p];
  seq_step_t cur;
  logic [sw-1:0] step_n, len_q;
  logic loop_q, dur_ld, gap_ld, lat, done_n, dur_last, gap_last, dur_end, gap_end, adv;
  logic [dur_width_p-1:0] dur_v;
  logic [nw-1:0] note;
  assign cur = mem[step_n];
  assign note = nw'(cur.note);
  assign dur_v = (cur.dur == '0) ? dur_width_p'(1) : dur_width_p'(cur.dur);
  assign dur_end = state == PLAY && sample_tick_i && dur_last;
  assign gap_end = state == GAP && sample_tick_i && gap_last;
  assign adv = gap_end || (dur_end && gap_ticks_p == 0);
  tick_down_counter #(.width_p(dur_width_p)) u_dur (
    .clk_i(clk_i), .reset_i(reset_i), .load_i(dur_ld), .val_i(dur_v),
    .tick_i(sample_tick_i && state == PLAY), .last_o(dur_last)
  );
  tick_down_counter #(.width_p(gw)) u_gap (
    .clk_i(clk_i), .reset_i(reset_i), .load_i(gap_ld), .val_i(gw'(gap_ticks_p)),
    .tick_i(sample_tick_i && state == GAP), .last_o(gap_last)
  );
  // pattern memory accepts writes only while idle and not being stopped
  always_ff @(posedge clk_i)
    if (cfg_we_i && !stop_i && state == IDLE)
      mem[cfg_addr_i] <= '{rest: cfg_rest_i, note: seq_note_w'(cfg_note_i), dur: seq_dur_w'(cfg_dur_i)};
  // next state: stop beats everything, then start, then step advance, then entry into the gap
  always_comb begin
    state_n = state;
    step_n = step_o;
    done_n = 1'b0;
    dur_ld = 1'b0;
    gap_ld = 1'b0;
    lat = 1'b0;
    if (stop_i) begin
      state_n = IDLE;
      step_n = '0;
    end else if (state == IDLE && start_i) begin
      state_n = PLAY;
      step_n = '0;
      dur_ld = 1'b1;
      lat = 1'b1;
    end else if (adv) begin
      if (step_o < len_q) begin
        state_n = PLAY;
        step_n = step_o + 1'b1;
        dur_ld = 1'b1;
      end else if (loop_q) begin
        state_n = PLAY;
        step_n = '0;
        dur_ld = 1'b1;
      end else begin
        state_n = IDLE;
        done_n = 1'b1;
      end
    end else if (dur_end) begin
      state_n = GAP;
      gap_ld = 1'b1;
    end
  end
  // state, latched run settings and registered outputs derived from the next state
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= IDLE;
      step_o <= '0;
      len_q <= '0;
      loop_q <= 1'b0;
      osc_en_o <= '0;
      gate_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state <= state_n;
      step_o <= step_n;
      if (lat) begin
        len_q <= len_i;
        loop_q <= loop_i;
      end
      osc_en_o <= (state_n == PLAY && !cur.rest) ? voices_p'(1) << note : '0;
      gate_o <= state_n == PLAY && !cur.rest;
      busy_o <= state_n != IDLE;
      done_o <= done_n;
    end
endmodule

// File: tb/tb_wave_note_sequencer.sv
// tb_wave_note_sequencer: randomized scoreboard bench for the note sequencer
module tb_wave_note_sequencer;
  typedef struct packed {
    logic [3:0] en;
    logic       gate;
    logic [3:0] step;
    logic       busy;
    logic       last;
  } exp_t;
  logic clk_i = 0, reset_i = 1, sample_tick_i = 0, start_i = 0, stop_i = 0, loop_i = 0;
  logic cfg_we_i = 0, cfg_rest_i = 0;
  logic [3:0] len_i = 0, cfg_addr_i = 0;
  logic [1:0] cfg_note_i = 0;
  logic [15:0] cfg_dur_i = 0;
  logic [3:0] osc_en_o, step_o;
  logic gate_o, busy_o, done_o;
  int checks = 0, failures = 0;
  bit tick_en = 0, pend_done = 0;
  bit m_rest [16];
  int m_note [16];
  int m_dur [16];
  exp_t q [$];

  wave_note_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .sample_tick_i(sample_tick_i), .start_i(start_i),
    .stop_i(stop_i), .loop_i(loop_i), .len_i(len_i), .cfg_we_i(cfg_we_i),
    .cfg_addr_i(cfg_addr_i), .cfg_rest_i(cfg_rest_i), .cfg_note_i(cfg_note_i),
    .cfg_dur_i(cfg_dur_i), .osc_en_o(osc_en_o), .gate_o(gate_o), .step_o(step_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] en, input logic g, input int s);
    mk = '{en: en, gate: g, step: 4'(s), busy: 1'b1, last: 1'b0};
  endfunction

  task automatic push_step(input int s);
    int d;
    logic [3:0] en;
    d = m_dur[s] == 0 ? 1 : m_dur[s];
    en = m_rest[s] ? 4'd0 : 4'(1 << m_note[s]);
    repeat (d) q.push_back(mk(en, !m_rest[s], s));
  endtask

  task automatic push_run(input int len, input bit loop, input int extra);
    exp_t t;
    for (int s = 0; s <= len; s++) begin
      push_step(s);
      repeat (4) q.push_back(mk(4'd0, 1'b0, s));
    end
    if (!loop) begin
      t = q.pop_back();
      t.last = 1'b1;
      q.push_back(t);
    end else begin
      for (int k = 0; k < extra; k++)
        q.push_back(mk(m_rest[0] ? 4'd0 : 4'(1 << m_note[0]), !m_rest[0], 0));
    end
  endtask

  task automatic write_cfg(input int a, input bit r, input int n, input int d, input bit upd);
    @(posedge clk_i); #1;
    cfg_we_i = 1; cfg_addr_i = 4'(a); cfg_rest_i = r; cfg_note_i = 2'(n); cfg_dur_i = 16'(d);
    @(posedge clk_i); #1;
    cfg_we_i = 0;
    if (upd) begin
      m_rest[a] = r; m_note[a] = n; m_dur[a] = d;
    end
  endtask

  task automatic start_run(input int len, input bit loop, input int extra);
    @(posedge clk_i); #1;
    start_i = 1; len_i = 4'(len); loop_i = loop;
    @(posedge clk_i); #1;
    start_i = 0;
    push_run(len, loop, extra);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || pend_done) && n < 20000) begin
      @(posedge clk_i);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      failures++;
      $display("FAIL drain: timeout with %0d entries left", q.size());
      q.delete();
      pend_done = 0;
    end
    #1;
  endtask

  initial forever begin
    @(posedge clk_i); #1;
    sample_tick_i = tick_en && ($urandom_range(0, 2) == 0);
  end

  initial forever begin
    exp_t e;
    @(negedge clk_i);
    if (pend_done) begin
      check("done_pulse", {30'd0, done_o, busy_o}, 32'b10);
      pend_done = 0;
    end else if (done_o) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
    end
    if (sample_tick_i && q.size() > 0) begin
      e = q.pop_front();
      check("tick_out", {22'd0, osc_en_o, gate_o, step_o, busy_o}, {22'd0, e.en, e.gate, e.step, e.busy});
      if (e.last) pend_done = 1;
    end
  end

  initial begin
    int n, sv;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_vals", {21'd0, osc_en_o, gate_o, step_o, busy_o, done_o}, 32'd0);
    reset_i = 0;
    write_cfg(0, 0, 1, 3, 1);
    write_cfg(1, 1, 0, 2, 1);
    write_cfg(2, 0, 3, 1, 1);
    tick_en = 1;
    start_run(2, 0, 0);
    drain();
    start_run(2, 1, 3);
    n = 0;
    while (q.size() > 10 && n < 5000) begin
      @(posedge clk_i);
      n++;
    end
    tick_en = 0;
    repeat (3) @(posedge clk_i);
    #1;
    write_cfg(0, 0, 3, 7, 0);
    sv = step_o;
    start_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
    @(posedge clk_i); #1;
    check("start_busy", {27'd0, step_o, busy_o}, {27'd0, 4'(sv), 1'b1});
    tick_en = 1;
    drain();
    tick_en = 0;
    @(posedge clk_i); #1;
    stop_i = 1;
    @(posedge clk_i); #1;
    stop_i = 0;
    check("stop_idle", {21'd0, osc_en_o, gate_o, step_o, busy_o, done_o}, 32'd0);
    tick_en = 1;
    start_run(2, 0, 0);
    drain();
    write_cfg(0, 0, 2, 0, 1);
    start_run(0, 0, 0);
    drain();
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(0, 5);
      for (int s = 0; s <= len; s++)
        write_cfg(s, $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 4), 1);
      start_run(len, 0, 0);
      drain();
    end
    tick_en = 0;
    @(posedge clk_i); #1;
    stop_i = 1; start_i = 1;
    @(posedge clk_i); #1;
    stop_i = 0; start_i = 0;
    check("stop_start_idle", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i); #1;
    check("stop_start_idle2", {31'd0, busy_o}, 32'd0);
    write_cfg(0, 0, 2, 9, 1);
    start_i = 1; len_i = 0; loop_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
    @(posedge clk_i); #1;
    check("play_before_reset", {26'd0, osc_en_o, gate_o, busy_o}, {26'd0, 4'b0100, 1'b1, 1'b1});
    #2;
    reset_i = 1;
    #1;
    check("async_reset", {21'd0, osc_en_o, gate_o, step_o, busy_o, done_o}, 32'd0);
    @(posedge clk_i); #1;
    reset_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check("no_resume", {27'd0, osc_en_o, busy_o}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
